// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control sequencer: Moore decode of the state register drives datapath selects and enables.
// Latency: outputs are combinational from state (pc_write/ir_write also from mem_ready/zero); one state step per clock.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with request and address select stable until mem_ready is seen.
module mc_ctrl_fsm #(
  parameter int                OP_W  = 6,
  parameter int                FN_W  = 6,
  parameter logic [FN_W-1:0]   FN_JR = 6'h08
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FN_W-1:0]   funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [3:0]        state,
  output logic              iord_sel,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pcsrc_sel,
  output logic [1:0]        regdst_sel,
  output logic [1:0]        memtoreg_sel,
  output logic              reg_write,
  output logic              alusrca_sel,
  output logic [1:0]        alusrcb_sel,
  output logic              imm_shift,
  output logic [1:0]        alu_op,
  output logic              illegal_op
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_JAL      = 4'd13
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'h03);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

  state_e state_q, state_d;

  assign state = state_q;

  // State register; reset drops straight to RST so memory requests vanish without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; everything defaults to 0 and each state raises only what it needs.
  always_comb begin
    state_d      = state_q;
    iord_sel     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pcsrc_sel    = 2'd0;
    regdst_sel   = 2'd0;
    memtoreg_sel = 2'd0;
    reg_write    = 1'b0;
    alusrca_sel  = 1'b0;
    alusrcb_sel  = 2'd0;
    imm_shift    = 1'b0;
    alu_op       = 2'd0;
    illegal_op   = 1'b0;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // PC + 4 is computed every cycle; it is only committed with the IR load.
        mem_read    = 1'b1;
        alusrcb_sel = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target speculatively computed into ALUOut.
        alusrcb_sel = 2'd2;
        imm_shift   = 1'b1;
        case (opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_JAL:        state_d = S_JAL;
          OP_ADDI:       state_d = S_I_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alusrca_sel = 1'b1;
        alusrcb_sel = 2'd2;
        state_d     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord_sel = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write    = 1'b1;
        memtoreg_sel = 2'd1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord_sel  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alusrca_sel = 1'b1;
        if (funct == FN_JR) begin
          // jr: regA passes through the adder (B operand is don't-care) straight into the PC.
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else begin
          alu_op  = 2'd2;
          state_d = S_R_WB;
        end
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        regdst_sel = 2'd1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_sel = 1'b1;
        alu_op      = 2'd1;
        pcsrc_sel   = 2'd1;
        pc_write    = (opcode == OP_BNE) ? ~zero : zero;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_sel = 2'd2;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so write-back of PC gives the link address.
        pcsrc_sel    = 2'd2;
        pc_write     = 1'b1;
        reg_write    = 1'b1;
        regdst_sel   = 2'd2;
        memtoreg_sel = 2'd2;
        state_d      = S_FETCH;
      end
      S_I_EXEC: begin
        alusrca_sel = 1'b1;
        alusrcb_sel = 2'd2;
        state_d     = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: per-instruction expected cycle scripts versus observed outputs.
// Latency: one comparison set per clock, sampled on the falling edge.
// Backpressure: mem_ready wait cycles are injected in FETCH, MEM_RD and MEM_WR.
module tb_mc_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [3:0] state;
  logic       iord_sel, mem_read, mem_write, ir_write, pc_write;
  logic [1:0] pcsrc_sel, regdst_sel, memtoreg_sel;
  logic       reg_write, alusrca_sel;
  logic [1:0] alusrcb_sel;
  logic       imm_shift;
  logic [1:0] alu_op;
  logic       illegal_op;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .state(state), .iord_sel(iord_sel), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pcsrc_sel(pcsrc_sel), .regdst_sel(regdst_sel), .memtoreg_sel(memtoreg_sel),
    .reg_write(reg_write), .alusrca_sel(alusrca_sel), .alusrcb_sel(alusrcb_sel),
    .imm_shift(imm_shift), .alu_op(alu_op), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, mrd, mwr, irw, pcw;
    logic [1:0] pcsrc, regdst, m2r;
    logic       rw, asrca;
    logic [1:0] asrcb;
    logic       imm;
    logic [1:0] aluop;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic mr;
    out_t e;
  } step_t;

  out_t  obs;
  step_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  assign obs = {state, iord_sel, mem_read, mem_write, ir_write, pc_write, pcsrc_sel,
                regdst_sel, memtoreg_sel, reg_write, alusrca_sel, alusrcb_sel,
                imm_shift, alu_op, illegal_op};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: an instruction is a script of named phases, each with the signals the phase asserts.
  function automatic out_t phase(input int st);
    out_t o;
    o = '0;
    o.st = st[3:0];
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08};
  endfunction

  task automatic push(input logic mr, input out_t e);
    step_t s;
    s.mr = mr;
    s.e  = e;
    q.push_back(s);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    out_t o;
    q.delete();
    for (int i = 0; i < fw; i++) begin
      o = phase(1); o.mrd = 1; o.asrcb = 2'd1;
      push(1'b0, o);
    end
    o = phase(1); o.mrd = 1; o.asrcb = 2'd1; o.irw = 1; o.pcw = 1;
    push(1'b1, o);
    o = phase(2); o.asrcb = 2'd2; o.imm = 1; o.ill = !is_legal(op);
    push(1'($urandom_range(0, 1)), o);
    if (op == 6'h00) begin
      o = phase(7); o.asrca = 1;
      if (fn == 6'h08) begin
        o.pcw = 1;
        push(1'($urandom_range(0, 1)), o);
      end else begin
        o.aluop = 2'd2;
        push(1'($urandom_range(0, 1)), o);
        o = phase(8); o.rw = 1; o.regdst = 2'd1;
        push(1'($urandom_range(0, 1)), o);
      end
    end else if (op == 6'h23 || op == 6'h2B) begin
      o = phase(3); o.asrca = 1; o.asrcb = 2'd2;
      push(1'($urandom_range(0, 1)), o);
      o = phase(op == 6'h23 ? 4 : 6); o.iord = 1;
      if (op == 6'h23) o.mrd = 1; else o.mwr = 1;
      for (int i = 0; i < mw; i++) push(1'b0, o);
      push(1'b1, o);
      if (op == 6'h23) begin
        o = phase(5); o.rw = 1; o.m2r = 2'd1;
        push(1'($urandom_range(0, 1)), o);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      o = phase(9); o.asrca = 1; o.aluop = 2'd1; o.pcsrc = 2'd1;
      o.pcw = (op == 6'h04) ? z : !z;
      push(1'($urandom_range(0, 1)), o);
    end else if (op == 6'h02) begin
      o = phase(10); o.pcsrc = 2'd2; o.pcw = 1;
      push(1'($urandom_range(0, 1)), o);
    end else if (op == 6'h03) begin
      o = phase(13); o.pcsrc = 2'd2; o.pcw = 1; o.rw = 1; o.regdst = 2'd2; o.m2r = 2'd2;
      push(1'($urandom_range(0, 1)), o);
    end else if (op == 6'h08) begin
      o = phase(11); o.asrca = 1; o.asrcb = 2'd2;
      push(1'($urandom_range(0, 1)), o);
      o = phase(12); o.rw = 1;
      push(1'($urandom_range(0, 1)), o);
    end
  endtask

  // Called just after a rising edge: drive, sample on the falling edge, compare.
  task automatic run_step(input string tag, input int idx);
    mem_ready = q[idx].mr;
    @(negedge clk);
    chk(tag, 32'(obs), 32'(q[idx].e));
    chk({tag, "_pcw_rw"}, 32'(pc_write & reg_write), 32'(q[idx].e.st == 4'd13));
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw);
    opcode = op; funct = fn; zero = z;
    build(op, fn, z, fw, mw);
    for (int i = 0; i < q.size(); i++) begin
      run_step(tag, i);
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] op_tab [8];
  logic [5:0] rop, rfn;
  int         ridx;

  initial begin
    op_tab[0] = 6'h00; op_tab[1] = 6'h23; op_tab[2] = 6'h2B; op_tab[3] = 6'h04;
    op_tab[4] = 6'h05; op_tab[5] = 6'h02; op_tab[6] = 6'h03; op_tab[7] = 6'h08;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk("reset_outputs", 32'(obs), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr("add",       6'h00, 6'h20, 1'b0, 0, 0);
    run_instr("lw_wait3",  6'h23, 6'h00, 1'b0, 0, 3);
    run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0);
    run_instr("beq_not",   6'h04, 6'h00, 1'b0, 0, 0);
    run_instr("bne_taken", 6'h05, 6'h00, 1'b0, 0, 0);
    run_instr("jal",       6'h03, 6'h00, 1'b0, 0, 0);
    run_instr("illegal",   6'h3F, 6'h00, 1'b0, 0, 0);
    run_instr("fetch_w5",  6'h08, 6'h00, 1'b0, 5, 0);
    run_instr("jr",        6'h00, 6'h08, 1'b0, 1, 0);
    run_instr("sw_wait2",  6'h2B, 6'h00, 1'b0, 0, 2);
    run_instr("j",         6'h02, 6'h00, 1'b1, 0, 0);

    // Async reset in the middle of a lw read wait.
    opcode = 6'h23; funct = '0; zero = 1'b0;
    build(6'h23, 6'h00, 1'b0, 0, 2);
    for (int i = 0; i < 4; i++) begin
      run_step("rst_lw", i);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_state", 32'(state), 32'd0);
    chk("rst_async_mrd", 32'(mem_read), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_rel_state", 32'(state), 32'd1);
    chk("rst_rel_mrd", 32'(mem_read), 32'd1);
    chk("rst_rel_iord", 32'(iord_sel), 32'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) rop = 6'($urandom);
      else begin
        ridx = $urandom_range(0, 7);
        rop = op_tab[ridx];
      end
      rfn = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom);
      run_instr("rand", rop, rfn, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle control sequencer for the MIPS datapath. It drives every datapath mux select (2:1 and 3:1 selects for PC, address, register-destination, write-back and ALU operands) and every write enable. It steps one instruction through fetch, decode, execute, memory and write-back states, and stalls on a memory ready handshake. It sits beside the datapath and takes the opcode/funct from the IR and the zero flag from the ALU.

Parameters:
OP_W, 6, opcode field width
FN_W, 6, funct field width
FN_JR, 6'h08, funct code decoded as jr (R-type with PC write, no register write)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OP_W  IR[31:26]
funct  in  FN_W  IR[5:0]
zero  in  1  ALU zero flag, valid in the BRANCH state
mem_ready  in  1  memory completes the current read/write this cycle
state  out  4  current state (debug)
iord_sel  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
pc_write  out  1  PC load enable (already qualified by branch condition)
pcsrc_sel  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
regdst_sel  out  2  0 = rt, 1 = rd, 2 = 5'd31
memtoreg_sel  out  2  0 = ALUOut, 1 = MDR, 2 = PC
reg_write  out  1  register file write enable
alusrca_sel  out  1  0 = PC, 1 = regA
alusrcb_sel  out  2  0 = regB, 1 = 32'd4, 2 = immediate
imm_shift  out  1  immediate is shifted left by 2 (branch offset)
alu_op  out  2  00 = add, 01 = sub, 10 = decode from funct
illegal_op  out  1  one-cycle pulse for an unsupported opcode

Behaviour:
- Encoding: RST=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12, JAL=13. Codes 14 and 15 go to RST on the next clock.
- Reset: rst_n low forces state=RST asynchronously. In RST every output is 0, state=0. The first clock after release moves to FETCH.
- Outputs are a Moore decode of state. Exceptions: pc_write and ir_write also depend on mem_ready or zero, as listed below. Every output not listed for a state is 0. The state register is the only storage.
- FETCH: mem_read=1, iord_sel=0, alusrca_sel=0, alusrcb_sel=1, alu_op=00, pcsrc_sel=0.
  - Hold while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
- DECODE: alusrca_sel=0, alusrcb_sel=2, imm_shift=1, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0x00 (R-type) -> R_EXEC
  - 0x23 (lw) or 0x2B (sw) -> MEM_ADDR
  - 0x04 (beq) or 0x05 (bne) -> BRANCH
  - 0x02 (j) -> JUMP
  - 0x03 (jal) -> JAL
  - 0x08 (addi) -> I_EXEC
  - any other opcode -> FETCH, with illegal_op=1 for this cycle
- MEM_ADDR: alusrca_sel=1, alusrcb_sel=2, alu_op=00. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord_sel=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, regdst_sel=0, memtoreg_sel=1. Next FETCH.
- MEM_WR: mem_write=1, iord_sel=1. Hold until mem_ready, then FETCH.
- R_EXEC: alusrca_sel=1, alusrcb_sel=0, alu_op=10.
  - funct==FN_JR: pcsrc_sel=0, pc_write=1, alu_op=00, alusrcb_sel=0 is ignored by the datapath; next FETCH.
  - Otherwise next R_WB.
- R_WB: reg_write=1, regdst_sel=1, memtoreg_sel=0. Next FETCH.
- BRANCH: alusrca_sel=1, alusrcb_sel=0, alu_op=01, pcsrc_sel=1. pc_write = zero for beq, ~zero for bne. Next FETCH.
- JUMP: pcsrc_sel=2, pc_write=1. Next FETCH.
- JAL: pcsrc_sel=2, pc_write=1, reg_write=1, regdst_sel=2, memtoreg_sel=2. The PC already holds PC+4 from FETCH. Next FETCH.
- I_EXEC: alusrca_sel=1, alusrcb_sel=2, imm_shift=0, alu_op=00. Next I_WB.
- I_WB: reg_write=1, regdst_sel=0, memtoreg_sel=0. Next FETCH.
- Cycles per instruction with zero wait states: R-type 4, jr 3, lw 5, sw 4, beq/bne 3, j 3, jal 3, addi 4. Each wait cycle adds 1.
- mem_read/mem_write stay asserted, with a stable address select, for the whole wait.
- An async reset during a memory wait drops mem_read/mem_write immediately. The instruction is not retried; after reset the PC state belongs to the datapath.
- pc_write and reg_write are never both 1, except in JAL.

Test Plan:
- Reset: rst_n=0 mid-MEM_RD -> state=0 and mem_read=0 with no clock; release -> FETCH one clock later with mem_read=1, iord_sel=0.
- add, opcode 0x00, funct 0x20, mem_ready=1 -> states 1,2,7,8,1. R_EXEC has alu_op=10; R_WB has reg_write=1, regdst_sel=1. 4 cycles total.
- lw, opcode 0x23, with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with iord_sel=1; MEM_WB has memtoreg_sel=1, regdst_sel=0. 8 cycles total.
- beq, opcode 0x04: zero=1 -> pc_write=1, pcsrc_sel=1. zero=0 -> pc_write=0. bne, opcode 0x05, with zero=0 -> pc_write=1.
- jal, opcode 0x03 -> JAL state has pc_write=1, pcsrc_sel=2, reg_write=1, regdst_sel=2, memtoreg_sel=2. 3 cycles total.
- opcode 0x3F -> illegal_op pulses for 1 cycle in DECODE, next state FETCH, no reg_write or mem_write at any point. FETCH with mem_ready=0 for 5 cycles -> ir_write and pc_write stay 0 until the ready cycle.
